pe_index_packer: RTL and testbench
==================================

Name: pe_index_packer

Overview:
Downstream stage of priority_encoder. Takes the registered one-hot left/right outputs (MSB-most and LSB-most set bit), converts them to binary indices and computes the occupied span. Flags malformed or empty words. Delivers results over a valid/ready stream through a 2-stage stallable pipeline.

Parameters:
WIDTH, 8, width of the one-hot input words; must be >= 2
IDX_W, $clog2(WIDTH), width of the binary index outputs (derived, not overridden)
CNT_W, 16, width of the saturating error counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
data_left_i  input  WIDTH  one-hot (or zero) MSB-most set bit from priority_encoder
data_right_i  input  WIDTH  one-hot (or zero) LSB-most set bit from priority_encoder
data_val_i  input  1  input word valid
data_ready_o  output  1  stage can accept a word this cycle
left_idx_o  output  IDX_W  binary index of left bit
right_idx_o  output  IDX_W  binary index of right bit
span_o  output  IDX_W+1  left_idx - right_idx + 1; 0 for empty/error words
zero_o  output  1  input word carried no set bit
err_o  output  1  input pair malformed
valid_o  output  1  output word valid
ready_i  input  1  downstream accepts the output word
err_cnt_o  output  CNT_W  count of accepted malformed words, saturating

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous and active low.
- Reset values: all outputs 0, including valid_o and err_cnt_o. Both pipeline valids are cleared.
- Transfer rules:
  - Input transfer occurs when data_val_i && data_ready_o.
  - Output transfer occurs when valid_o && ready_i.
- S1 (encode register):
  - Latches the binary index of each input.
  - Classifies the word:
    - zero: both inputs 0.
    - err: any of the following: either input has popcount > 1; exactly one input is zero; right index > left index.
    - Otherwise the word is valid.
- S2 (output register):
  - Computes span from S1 indices and drives all outputs.
  - Zero or err word: indices 0 and span 0.
  - err and zero are mutually exclusive.
- Latency: 2 cycles from input transfer to valid_o with no backpressure. Throughput is 1 word per cycle.
- Stall logic:
  - s2_adv = !s2_vld || ready_i.
  - s1_adv = !s1_vld || s2_adv.
  - data_ready_o = s1_adv, a combinational path from ready_i.
- Output stability: while valid_o && !ready_i, all outputs hold stable. No word is lost or duplicated, and order is preserved.
- Bubbles: if S1 is empty while S2 advances, S2 becomes empty and valid_o drops.
- Error counter:
  - err_cnt_o increments by 1 when an err word transfers into S1.
  - It saturates at 2**CNT_W-1 and never wraps.
  - It is cleared only by reset.
- Simultaneous events: input transfer and output transfer in the same cycle are legal at full throughput. Both happen.
- Reset mid-operation: in-flight words are discarded immediately (asynchronous). valid_o drops without waiting for ready_i, and err_cnt_o returns to 0.
- Boundary cases:
  - Left = right = bit 0: indices 0, span 1.
  - Left = bit WIDTH-1, right = bit 0: span WIDTH, which requires IDX_W+1 bits.

Decomposition:
- Package pe_pkg holds:
  - the function for one-hot to binary index conversion, returning index plus a multi-hot flag;
  - the result struct {left_idx, right_idx, span, zero, err} used as the S1/S2 payload.
- One sub-module, pe_onehot2bin (WIDTH param), is instantiated twice in S1: once for the left input, once for the right.
- The pipeline/handshake stays in the top module.

Test Plan:
1. WIDTH=8, ready_i=1: left=8'b1000_0000, right=8'b0000_0100 -> 2 cycles later valid_o=1, left_idx=7, right_idx=2, span=6, zero=0, err=0.
2. left=right=8'b0000_0001 -> left_idx=0, right_idx=0, span=1. Then left=right=8'b0000_0000 -> zero_o=1, span=0, err_o=0, err_cnt_o unchanged.
3. Malformed inputs: left=8'b0000_0011, right=8'b0000_0001 -> err_o=1, span=0, err_cnt_o=1. Then left=8'b0000_0010, right=8'b0000_1000 -> err_o=1, err_cnt_o=2.
4. Backpressure: stream 3 words back-to-back (spans 8, 4, 1) with ready_i=0 for 4 cycles -> data_ready_o=0 after the 2nd accepted word, output holds span=8 stable, third word not accepted until ready_i=1. Afterwards spans 8, 4, 1 emerge in order on consecutive cycles.
5. Saturation: set CNT_W=2 and apply 5 err words -> err_cnt_o sequence 1, 2, 3, 3, 3.
6. Reset mid-operation: assert rst_ni=0 between clock edges while S1 and S2 are full and ready_i=0 -> valid_o=0 and err_cnt_o=0 immediately. After release, the first new word appears 2 cycles after acceptance with no stale data.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and the one-hot decode helper for the priority-encoder index packer.
// Types are sized for the largest supported word; instances use the low bits.
package pe_pkg;

  localparam int unsigned MAX_WIDTH = 256;
  localparam int unsigned IDX_MAX   = 8;

  typedef struct packed {
    logic [IDX_MAX-1:0] idx;
    logic               multi;
  } oh_conv_t;

  typedef struct packed {
    logic [IDX_MAX-1:0] left_idx;
    logic [IDX_MAX-1:0] right_idx;
    logic [IDX_MAX:0]   span;
    logic               zero;
    logic               err;
  } result_t;

  // The index is only meaningful when exactly one bit is set.
  function automatic oh_conv_t onehot2bin(input logic [MAX_WIDTH-1:0] onehot);
    oh_conv_t r;
    logic     seen;
    r    = '0;
    seen = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (onehot[i]) begin
        if (seen) r.multi = 1'b1;
        r.idx = IDX_MAX'(i);
        seen  = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_onehot2bin.sv
// One-hot to binary index converter with multi-hot and all-zero flags.
module pe_onehot2bin
  import pe_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             multi_o,
  output logic             zero_o
);

  oh_conv_t conv;

  always_comb begin
    conv = onehot2bin(MAX_WIDTH'(onehot_i));
  end

  assign idx_o   = conv.idx[IDX_W-1:0];
  assign multi_o = conv.multi;
  assign zero_o  = ~|onehot_i;

  // Upper index bits are always zero for this WIDTH.
  if (IDX_W < IDX_MAX) begin : g_idx_hi
    logic unused_idx_hi;
    assign unused_idx_hi = ^conv.idx[IDX_MAX-1:IDX_W];
  end

endmodule

// File: rtl/pe_index_packer.sv
// Converts priority-encoder left/right one-hot words to indices and span,
// flags empty/malformed words, and streams results through a 2-stage stallable pipe.
module pe_index_packer
  import pe_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [IDX_W-1:0] left_idx_o,
  output logic [IDX_W-1:0] right_idx_o,
  output logic [IDX_W:0]   span_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] err_cnt_o
);

  logic [IDX_W-1:0] l_idx, r_idx;
  logic             l_multi, r_multi, l_zero, r_zero;

  pe_onehot2bin #(.WIDTH(WIDTH)) u_left (
    .onehot_i (data_left_i),
    .idx_o    (l_idx),
    .multi_o  (l_multi),
    .zero_o   (l_zero)
  );

  pe_onehot2bin #(.WIDTH(WIDTH)) u_right (
    .onehot_i (data_right_i),
    .idx_o    (r_idx),
    .multi_o  (r_multi),
    .zero_o   (r_zero)
  );

  result_t          enc;
  result_t          s1_q, s1_d, s2_q, s2_d;
  logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             s1_adv, s2_adv, in_fire;

  always_comb begin
    enc           = '0;
    enc.left_idx  = IDX_MAX'(l_idx);
    enc.right_idx = IDX_MAX'(r_idx);
    enc.zero      = l_zero & r_zero;
    enc.err       = l_multi | r_multi | (l_zero ^ r_zero)
                  | (!l_zero && !r_zero && (r_idx > l_idx));
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    s2_adv    = !s2_vld_q || ready_i;
    s1_adv    = !s1_vld_q || s2_adv;
    in_fire   = data_val_i && s1_adv;
    s1_vld_d  = s1_vld_q;
    s1_d      = s1_q;
    s2_vld_d  = s2_vld_q;
    s2_d      = s2_q;
    err_cnt_d = err_cnt_q;

    if (s1_adv) s1_vld_d = data_val_i;
    if (in_fire) s1_d = enc;

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_d = s1_q;
        if (s1_q.zero || s1_q.err) begin
          s2_d.left_idx  = '0;
          s2_d.right_idx = '0;
          s2_d.span      = '0;
        end else begin
          s2_d.span = (IDX_MAX+1)'(s1_q.left_idx) - (IDX_MAX+1)'(s1_q.right_idx)
                    + (IDX_MAX+1)'(1);
        end
      end
    end

    if (in_fire && enc.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; all flops reset
  // asynchronously so in-flight words vanish the moment rst_ni falls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      err_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign data_ready_o = s1_adv;
  assign valid_o      = s2_vld_q;
  assign left_idx_o   = s2_q.left_idx[IDX_W-1:0];
  assign right_idx_o  = s2_q.right_idx[IDX_W-1:0];
  assign span_o       = s2_q.span[IDX_W:0];
  assign zero_o       = s2_q.zero;
  assign err_o        = s2_q.err;
  assign err_cnt_o    = err_cnt_q;

  if (IDX_W < IDX_MAX) begin : g_out_hi
    logic unused_out_hi;
    assign unused_out_hi = ^{s2_q.left_idx[IDX_MAX-1:IDX_W],
                             s2_q.right_idx[IDX_MAX-1:IDX_W],
                             s2_q.span[IDX_MAX:IDX_W+1]};
  end

endmodule

// File: tb/tb_pe_index_packer.sv
// Self-checking bench for pe_index_packer: directed vectors, backpressure,
// counter saturation, mid-operation reset and randomized scoreboard traffic.
module tb_pe_index_packer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] data_left_i = '0, data_right_i = '0;
  logic       data_val_i = 1'b0, ready_i = 1'b0;
  logic       data_ready_o, zero_o, err_o, valid_o;
  logic [2:0] left_idx_o, right_idx_o;
  logic [3:0] span_o;
  logic [CNT_W-1:0] err_cnt_o;

  logic       sat_data_ready, sat_zero, sat_err, sat_valid;
  logic [2:0] sat_left_idx, sat_right_idx;
  logic [3:0] sat_span;
  logic [1:0] sat_err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  pe_index_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_left_i(data_left_i), .data_right_i(data_right_i),
    .data_val_i(data_val_i), .data_ready_o(data_ready_o), .left_idx_o(left_idx_o),
    .right_idx_o(right_idx_o), .span_o(span_o), .zero_o(zero_o), .err_o(err_o),
    .valid_o(valid_o), .ready_i(ready_i), .err_cnt_o(err_cnt_o)
  );

  pe_index_packer #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_left_i(data_left_i), .data_right_i(data_right_i),
    .data_val_i(data_val_i), .data_ready_o(sat_data_ready), .left_idx_o(sat_left_idx),
    .right_idx_o(sat_right_idx), .span_o(sat_span), .zero_o(sat_zero), .err_o(sat_err),
    .valid_o(sat_valid), .ready_i(ready_i), .err_cnt_o(sat_err_cnt)
  );

  typedef struct {
    logic [7:0]  l;
    logic [7:0]  r;
    logic [11:0] exp;   // {left_idx, right_idx, span, zero, err}
    int          cnt;   // err_cnt_o after this word
  } vec_t;

  vec_t vecs[10];
  logic [11:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [11:0] out_word();
    return {left_idx_o, right_idx_o, span_o, zero_o, err_o};
  endfunction

  // Reference: derived directly from popcounts and bit positions.
  function automatic logic [11:0] model(input logic [7:0] l, input logic [7:0] r);
    int cl, cr, li, ri, sp;
    bit z, e;
    cl = $countones(l);
    cr = $countones(r);
    li = 0;
    ri = 0;
    for (int i = 0; i < 8; i++) if (l[i]) li = i;
    for (int i = 7; i >= 0; i--) if (r[i]) ri = i;
    z = (cl == 0) && (cr == 0);
    e = (cl > 1) || (cr > 1) || ((cl == 0) != (cr == 0)) || (!z && ri > li);
    if (z || e) begin
      li = 0;
      ri = 0;
      sp = 0;
    end else begin
      sp = li - ri + 1;
    end
    return {3'(li), 3'(ri), 4'(sp), z, e};
  endfunction

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic apply_reset(input string tag);
    #3;
    rst_ni = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_errcnt"}, 32'(err_cnt_o), 32'd0);
    #3;
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, n;
    logic acc, outx;
    logic [11:0] e;

    vecs[0] = '{8'h80, 8'h04, {3'd7, 3'd2, 4'd6, 1'b0, 1'b0}, 0};
    vecs[1] = '{8'h01, 8'h01, {3'd0, 3'd0, 4'd1, 1'b0, 1'b0}, 0};
    vecs[2] = '{8'h00, 8'h00, {3'd0, 3'd0, 4'd0, 1'b1, 1'b0}, 0};
    vecs[3] = '{8'h03, 8'h01, {3'd0, 3'd0, 4'd0, 1'b0, 1'b1}, 1};
    vecs[4] = '{8'h02, 8'h08, {3'd0, 3'd0, 4'd0, 1'b0, 1'b1}, 2};
    vecs[5] = '{8'h80, 8'h01, {3'd7, 3'd0, 4'd8, 1'b0, 1'b0}, 2};
    vecs[6] = '{8'h10, 8'h00, {3'd0, 3'd0, 4'd0, 1'b0, 1'b1}, 3};
    vecs[7] = '{8'h40, 8'h40, {3'd6, 3'd6, 4'd1, 1'b0, 1'b0}, 3};
    vecs[8] = '{8'h00, 8'h20, {3'd0, 3'd0, 4'd0, 1'b0, 1'b1}, 4};
    vecs[9] = '{8'h20, 8'h02, {3'd5, 3'd1, 4'd5, 1'b0, 1'b0}, 4};

    // Reset state
    #2;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_outs", 32'(out_word()), 32'd0);
    check("rst_errcnt", 32'(err_cnt_o), 32'd0);
    #10;
    rst_ni = 1'b1;
    tick();

    // Directed vectors, one word at a time, 2-cycle latency
    ready_i = 1'b1;
    foreach (vecs[k]) begin
      data_left_i  = vecs[k].l;
      data_right_i = vecs[k].r;
      data_val_i   = 1'b1;
      tick();
      data_val_i = 1'b0;
      check($sformatf("vec%0d_lat1_valid", k), 32'(valid_o), 32'd0);
      tick();
      check($sformatf("vec%0d_valid", k), 32'(valid_o), 32'd1);
      check($sformatf("vec%0d_out", k), 32'(out_word()), 32'(vecs[k].exp));
      check($sformatf("vec%0d_errcnt", k), 32'(err_cnt_o), 32'(vecs[k].cnt));
    end
    tick();

    // Backpressure: spans 8, 4, 1 with ready_i low
    ready_i = 1'b0;
    data_val_i = 1'b1;
    data_left_i = 8'h80; data_right_i = 8'h01;
    check("bp_ready_w0", 32'(data_ready_o), 32'd1);
    tick();
    data_left_i = 8'h08; data_right_i = 8'h01;
    check("bp_ready_w1", 32'(data_ready_o), 32'd1);
    tick();
    data_left_i = 8'h04; data_right_i = 8'h04;
    for (int c = 0; c < 3; c++) begin
      check("bp_stall_ready", 32'(data_ready_o), 32'd0);
      check("bp_hold_valid", 32'(valid_o), 32'd1);
      check("bp_hold_span", 32'(span_o), 32'd8);
      if (c < 2) tick();
    end
    ready_i = 1'b1;
    #1;
    check("bp_release_ready", 32'(data_ready_o), 32'd1);
    tick();
    data_val_i = 1'b0;
    check("bp_out2_span", 32'(span_o), 32'd4);
    check("bp_out2_valid", 32'(valid_o), 32'd1);
    tick();
    check("bp_out3_span", 32'(span_o), 32'd1);
    check("bp_out3_valid", 32'(valid_o), 32'd1);
    tick();
    check("bp_bubble_valid", 32'(valid_o), 32'd0);

    // Saturation of a 2-bit counter
    apply_reset("sat_rst");
    data_left_i = 8'h03; data_right_i = 8'h01;
    data_val_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("sat_cnt%0d", k), 32'(sat_err_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
    data_val_i = 1'b0;
    tick();

    // Reset with both stages full and stalled
    ready_i = 1'b0;
    data_val_i = 1'b1;
    data_left_i = 8'h03; data_right_i = 8'h01;
    tick();
    data_left_i = 8'h80; data_right_i = 8'h01;
    tick();
    data_val_i = 1'b0;
    check("mid_full_valid", 32'(valid_o), 32'd1);
    check("mid_full_ready", 32'(data_ready_o), 32'd0);
    apply_reset("mid_rst");
    ready_i = 1'b1;
    data_val_i = 1'b1;
    data_left_i = 8'h20; data_right_i = 8'h04;
    tick();
    data_val_i = 1'b0;
    check("mid_no_stale", 32'(valid_o), 32'd0);
    tick();
    check("mid_new_valid", 32'(valid_o), 32'd1);
    check("mid_new_out", 32'(out_word()), 32'({3'd5, 3'd2, 4'd4, 1'b0, 1'b0}));

    // Randomized traffic against the scoreboard
    apply_reset("rand_rst");
    errs = 0;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      data_val_i = ($urandom_range(3) != 0);
      ready_i    = ($urandom_range(3) != 0);
      case ($urandom_range(9))
        0: begin data_left_i = '0; data_right_i = '0; end
        1, 2, 3, 4: begin
          int a, b;
          a = $urandom_range(7);
          b = $urandom_range(a);
          data_left_i  = 8'(1 << a);
          data_right_i = 8'(1 << b);
        end
        default: begin
          data_left_i  = 8'($urandom);
          data_right_i = 8'($urandom);
        end
      endcase
      @(negedge clk_i);
      check("rand_ready", 32'(data_ready_o), 32'(!(n == 2 && !ready_i)));
      check("rand_errcnt", 32'(err_cnt_o), 32'(errs));
      if (valid_o) begin
        if (sb.size() == 0) check("rand_unexpected_valid", 32'(valid_o), 32'd0);
        else check("rand_out", 32'(out_word()), 32'(sb[0]));
      end
      acc  = data_val_i && data_ready_o;
      outx = valid_o && ready_i;
      if (outx && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        e = model(data_left_i, data_right_i);
        sb.push_back(e);
        if (e[0]) errs++;
      end
      n = n + int'(acc) - int'(outx);
      tick();
    end
    data_val_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      @(negedge clk_i);
      if (valid_o) begin
        check("drain_out", 32'(out_word()), 32'(sb[0]));
        void'(sb.pop_front());
      end
      tick();
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("final_errcnt", 32'(err_cnt_o), 32'(errs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
